im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Writer-side companion to the single-cycle instruction memory (64 x 32-bit, 6-bit word address).
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit big-endian (MIPS) instruction words.
- Drives the memory write port (wr_en/wr_addr/wr_data) and holds the CPU off with cpu_hold until the program image is complete.
- Sits between the host/UART byte source and the instruction memory; the CPU fetch path reads the same memory after done.

Parameters:
- NWORDS, 64, number of words to load before automatic completion (1..64).
- AW, 6, word-address width; must satisfy 2**AW >= NWORDS.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: begin a new load at address 0
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in is valid
- byte_last  input  1  qualifies byte_in as the final byte of the image
- byte_ready  output  1  loader accepts byte_in this cycle
- wr_en  output  1  instruction-memory write strobe, one cycle per word
- wr_addr  output  AW  instruction-memory word address
- wr_data  output  32  instruction word
- busy  output  1  load in progress
- done  output  1  image complete; level, held until next start
- cpu_hold  output  1  keep CPU/PC in reset
- word_count  output  AW+1  words written in the current or last load

Behaviour:
- Reset (async, rst_n=0) forces: state IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, cpu_hold=1, word_count=0, byte index=0, shift register=0.
- Reset mid-load abandons the partial word; no write is issued and memory contents are left as written.
- Handshake: a byte transfers on a rising edge with byte_valid and byte_ready both high. byte_ready is a registered state decode; it does not depend combinationally on byte_valid.
- FSM states:
  - IDLE: byte_ready=0, busy=0, cpu_hold=1. start -> LOAD.
  - LOAD: byte_ready=1, busy=1, cpu_hold=1. Exits on the last-word condition or on byte_last -> DONE.
  - DONE: byte_ready=0, busy=0, done=1, cpu_hold=0. start -> LOAD.
- Entering LOAD from start clears wr_addr, word_count, byte index and done.
- Byte packing:
  - Byte index 0..3; byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - On acceptance of byte 3, the assembled word appears on wr_data with wr_en=1 on the NEXT cycle (latency 1). wr_addr holds the word's address during that cycle and increments after.
  - word_count increments in the same cycle wr_en is high.
  - byte_ready stays high during the write cycle; back-to-back bytes are sustained at 1 byte/clk.
- byte_last handling:
  - byte_last on an accepted byte with index < 3: the remaining lower bytes are zero-filled and the word is written next cycle.
  - Any byte_last acceptance -> DONE after that write.
- Capacity: when the word at address NWORDS-1 is written, the FSM moves to DONE regardless of byte_last. Further bytes are refused (byte_ready=0). wr_addr never wraps.
- Boundary conditions:
  - start while in LOAD is ignored.
  - start in IDLE/DONE with byte_valid already high: no byte is accepted in the start cycle; the first transfer happens the cycle after.
  - byte_valid while not ready: the byte is held by the source, not dropped.
  - A zero-byte image (start, then no bytes) stays in LOAD indefinitely; cpu_hold stays 1.
- wr_en is never high for two words in the same cycle, and is never high outside the write cycle.

Decomposition:
- Shared package im_pkg:
  - IM_DEPTH=64, IM_AW=6.
  - Loader state encoding: IDLE=2'd0, LOAD=2'd1, DONE=2'd2.
  - Byte-lane ordering constant BIG_ENDIAN=1.
- One natural sub-module, im_word_packer: byte index counter, shift/zero-fill, one-cycle write-strobe register.
- The FSM, address and count logic live in im_loader.

Test Plan:
- Reset then start; send bytes 20 08 00 20 -> one wr_en pulse, wr_addr=0, wr_data=32'h20080020, word_count=1 the cycle after the 4th byte.
- Stream 8 bytes at 1 byte/clk with byte_last on byte 8 -> writes 32'h20080020 at addr 0 and 32'h20090037 at addr 1, no stall, then done=1, cpu_hold=0.
- byte_last on the 2nd byte, data AA BB -> wr_data=32'hAABB0000 at addr 0, then DONE.
- NWORDS=4, feed 20 bytes -> exactly 4 writes (addr 0..3), done=1, byte_ready=0 from then on, bytes 17..20 never accepted.
- Assert rst_n=0 after 2 bytes of word 1, then start -> no write for the partial word, next full word lands at addr 0, word_count restarts at 1.
- start pulsed in LOAD after 3 bytes -> ignored; the 4th byte completes the word at the current address.

Source files
------------

// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared constants, loader state encoding and byte-lane helper
package im_pkg;

  localparam int IM_DEPTH = 64;
  localparam int IM_AW = 6;
  localparam bit BIG_ENDIAN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // Bit position of the lowest bit of byte lane idx within a 32-bit word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] idx);
    return BIG_ENDIAN ? {~idx, 3'b000} : {idx, 3'b000};
  endfunction

endpackage

// File: rtl/im_word_packer.sv
// rtl/im_word_packer.sv - packs accepted bytes into 32-bit words with zero-fill on last
module im_word_packer
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic        complete_o,
  output logic        wr_en_o,
  output logic [31:0] wr_data_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] merged;

  always_comb begin
    idx_d      = idx_q;
    shift_d    = shift_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    // Lanes below idx are still zero in shift_q, which gives the zero-fill for free.
    merged     = shift_q | ({24'd0, byte_i} << lane_lsb(idx_q));
    complete_o = accept_i && ((idx_q == 2'd3) || last_i);
    if (clear_i) begin
      idx_d   = 2'd0;
      shift_d = 32'd0;
    end else if (accept_i) begin
      if (complete_o) begin
        idx_d     = 2'd0;
        shift_d   = 32'd0;
        wr_en_d   = 1'b1;
        wr_data_d = merged;
      end else begin
        idx_d   = idx_q + 2'd1;
        shift_d = merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= 2'd0;
      shift_q   <= 32'd0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 32'd0;
    end else begin
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-stream loader for the instruction memory with CPU hold-off
module im_loader
  import im_pkg::*;
#(
  parameter int NWORDS = IM_DEPTH,
  parameter int AW     = IM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic          byte_last,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic [AW:0]   word_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

  ld_state_e     state_q, state_d;
  logic          ready_q, ready_d;
  logic          closing_q, closing_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] cur_addr;
  logic          accept, clear, complete;

  assign accept = byte_valid && ready_q;
  assign clear  = start && (state_q != ST_LOAD);

  im_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .accept_i   (accept),
    .byte_i     (byte_in),
    .last_i     (byte_last),
    .complete_o (complete),
    .wr_en_o    (wr_en),
    .wr_data_o  (wr_data)
  );

  // A word completed during a write cycle belongs to the next address.
  assign cur_addr = wr_en ? addr_q + 1'b1 : addr_q;

  always_comb begin
    state_d   = state_q;
    closing_d = closing_q;
    addr_d    = addr_q;
    count_d   = count_q;
    busy      = 1'b0;
    done      = 1'b0;
    cpu_hold  = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          done     = 1'b1;
          cpu_hold = 1'b0;
        end
        if (start) begin
          state_d   = ST_LOAD;
          closing_d = 1'b0;
          addr_d    = '0;
          count_d   = '0;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (complete) begin
          count_d = count_q + 1'b1;
          if (byte_last || (cur_addr == LAST_ADDR)) closing_d = 1'b1;
        end
        if (wr_en && (addr_q != LAST_ADDR)) addr_d = addr_q + 1'b1;
        if (wr_en && closing_q) begin
          state_d   = ST_DONE;
          closing_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Drop ready as soon as the final byte is taken so nothing slips in during the last write.
    ready_d = (state_d == ST_LOAD) && !closing_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      closing_q <= 1'b0;
      addr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      closing_q <= closing_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
    end
  end

  assign byte_ready = ready_q;
  assign wr_addr    = addr_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed and randomized checks of im_loader against a stream model
module tb_im_loader;

  localparam int NW  = 4;
  localparam int AWT = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     byte_in = 8'd0;
  logic           byte_valid = 1'b0;
  logic           byte_last = 1'b0;
  logic           byte_ready, wr_en, busy, done, cpu_hold;
  logic [AWT-1:0] wr_addr;
  logic [31:0]    wr_data;
  logic [AWT:0]   word_count;

  int ncomp = 0;
  int nfail = 0;
  int cyc = 0;
  int acc_cyc[$];
  int wr_cyc[$];
  int wr_aq[$];
  int wr_cq[$];
  logic [31:0] wr_dq[$];
  logic [7:0]  tx[$];

  im_loader #(.NWORDS(NW), .AW(AWT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .cpu_hold(cpu_hold), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) acc_cyc.push_back(cyc);
      if (wr_en) begin
        wr_cyc.push_back(cyc);
        wr_aq.push_back(int'(wr_addr));
        wr_cq.push_back(int'(word_count));
        wr_dq.push_back(wr_data);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    acc_cyc.delete(); wr_cyc.delete(); wr_aq.delete(); wr_cq.delete(); wr_dq.delete();
  endtask

  task automatic begin_run();
    clear_obs();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Present tx[from..upto-1]; a byte the loader refuses for 20 cycles ends the stream.
  task automatic send(input int from, input int upto, input bit use_last, input int maxgap);
    int g;
    bit got;
    for (int i = from; i < upto; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      if (g > 0) begin
        byte_valid = 1'b0;
        tick(g);
      end
      byte_in    = tx[i];
      byte_valid = 1'b1;
      byte_last  = use_last && (i == upto - 1);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (byte_ready) got = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!got) break;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  // Expected image: big-endian words from the stream, zero-filled, capped at NW words.
  task automatic check_run(input string tag, input int n, input bit use_last);
    int nwords, exp_acc, li;
    bit exp_done;
    logic [31:0] w;
    tick(3);
    nwords   = use_last ? (n + 3) / 4 : n / 4;
    if (nwords > NW) nwords = NW;
    exp_acc  = (!use_last && n > 4 * NW) ? 4 * NW : n;
    exp_done = use_last || (nwords == NW);
    chk({tag, ".accepted"}, acc_cyc.size(), exp_acc);
    chk({tag, ".writes"}, wr_dq.size(), nwords);
    for (int k = 0; k < nwords && k < wr_dq.size(); k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < n) w[31 - 8 * b -: 8] = tx[4 * k + b];
      chk($sformatf("%s.data%0d", tag, k), wr_dq[k], w);
      chk($sformatf("%s.addr%0d", tag, k), wr_aq[k], k);
      chk($sformatf("%s.count%0d", tag, k), wr_cq[k], k + 1);
      li = (4 * k + 3 < n) ? 4 * k + 3 : n - 1;
      if (li < acc_cyc.size())
        chk($sformatf("%s.latency%0d", tag, k), wr_cyc[k] - acc_cyc[li], 1);
    end
    chk({tag, ".done"}, done, exp_done);
    chk({tag, ".cpu_hold"}, cpu_hold, !exp_done);
    chk({tag, ".busy"}, busy, !exp_done);
    chk({tag, ".byte_ready"}, byte_ready, !exp_done);
    chk({tag, ".wr_en_idle"}, wr_en, 1'b0);
  endtask

  initial begin
    int n;
    bit ul;

    tick(2);
    chk("rst.byte_ready", byte_ready, 1'b0);
    chk("rst.wr_en", wr_en, 1'b0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 32'd0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.cpu_hold", cpu_hold, 1'b1);
    chk("rst.word_count", word_count, 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle.byte_ready", byte_ready, 1'b0);

    // One word, with byte_valid already high while start is pulsed.
    tx = '{8'h20, 8'h08, 8'h00, 8'h20};
    clear_obs();
    byte_in = 8'h20; byte_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("start_cycle.byte_ready", byte_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    send(0, 4, 1'b0, 0);
    tick(2);
    chk("s1.writes", wr_dq.size(), 1);
    if (wr_dq.size() > 0) chk("s1.data", wr_dq[0], 32'h20080020);
    chk("s1.busy", busy, 1'b1);

    // start inside LOAD is ignored; the next word continues at address 1.
    for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
    send(4, 7, 1'b0, 1);
    start = 1'b1; tick(1); start = 1'b0;
    send(7, 8, 1'b1, 0);
    check_run("s1", 8, 1'b1);

    // Eight bytes back to back.
    tx = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
    begin_run();
    send(0, 8, 1'b1, 0);
    check_run("s2", 8, 1'b1);
    if (acc_cyc.size() == 8) chk("s2.no_stall", acc_cyc[7] - acc_cyc[0], 7);

    // Short final word zero-filled.
    tx = '{8'hAA, 8'hBB};
    begin_run();
    send(0, 2, 1'b1, 1);
    check_run("s3", 2, 1'b1);

    // Capacity: 20 bytes offered, only NW words taken.
    tx.delete();
    for (int i = 0; i < 20; i++) tx.push_back(8'($urandom));
    begin_run();
    send(0, 20, 1'b0, 2);
    check_run("cap", 20, 1'b0);

    // Reset in the middle of a word.
    tx.delete();
    for (int i = 0; i < 2; i++) tx.push_back(8'($urandom));
    begin_run();
    send(0, 2, 1'b0, 0);
    rst_n = 1'b0;
    tick(1);
    chk("midrst.wr_en", wr_en, 1'b0);
    chk("midrst.cpu_hold", cpu_hold, 1'b1);
    rst_n = 1'b1;
    tick(3);
    chk("midrst.no_write", wr_dq.size(), 0);
    tx.delete();
    for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
    begin_run();
    send(0, 4, 1'b0, 1);
    check_run("midrst", 4, 1'b0);

    // Zero-byte image stays in LOAD.
    do_reset();
    begin_run();
    tick(10);
    chk("empty.busy", busy, 1'b1);
    chk("empty.cpu_hold", cpu_hold, 1'b1);
    chk("empty.done", done, 1'b0);
    chk("empty.writes", wr_dq.size(), 0);

    for (int it = 0; it < 10; it++) begin
      do_reset();
      n  = int'($urandom_range(1, 4 * NW));
      ul = 1'($urandom_range(0, 1));
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
      begin_run();
      send(0, n, ul, int'($urandom_range(0, 2)));
      check_run($sformatf("rnd%0d", it), n, ul);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
